// File: rtl/lieat_wbarb_pkg.sv
// lieat_wbarb_pkg: shared defaults and width helpers for the EXU writeback arbiter.
package lieat_wbarb_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int RGIDX_SIZE_DEF = 5;
    localparam int AGE_LIM_DEF    = 7;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    // Index width for a channel count; never narrower than one bit.
    function automatic int idw(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lieat_wbarb_age.sv
// lieat_wbarb_age: saturating starvation counter for one long writeback channel.
// Only built when LIEAT_WBARB_AGE_EN is defined.
`ifdef LIEAT_WBARB_AGE_EN
module lieat_wbarb_age
    import lieat_wbarb_pkg::*;
#(
    parameter int AGE_LIM = AGE_LIM_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    input  logic grant_i,
    output logic aged_o
);

    localparam int AW = clog2(AGE_LIM + 1);

    logic [AW-1:0] age_q, age_d;

    assign aged_o = (age_q == AW'(AGE_LIM));

    always_comb begin
        age_d = (!valid_i || grant_i) ? '0 : aged_o ? age_q : age_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) age_q <= '0;
        else     age_q <= age_d;
    end

endmodule
`endif

// File: rtl/lieat_exu_wbarb.sv
// lieat_exu_wbarb: single-port regfile writeback arbiter between the commit path and NLONG long channels.
// Macro LIEAT_WBARB_AGE_EN adds per-channel starvation counters and an aged priority level.
module lieat_exu_wbarb
    import lieat_wbarb_pkg::*;
#(
    parameter int NLONG      = 2,
    parameter int XLEN       = XLEN_DEF,
    parameter int RGIDX_SIZE = RGIDX_SIZE_DEF,
    parameter int AGE_LIM    = AGE_LIM_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        com_wbck_valid,
    output logic                        com_wbck_ready,
    input  logic [XLEN-1:0]             com_wbck_pc,
    input  logic                        com_wbck_en,
    input  logic [RGIDX_SIZE-1:0]       com_wbck_rd,
    input  logic [XLEN-1:0]             com_wbck_data,
    input  logic [NLONG-1:0]            long_wbck_valid,
    output logic [NLONG-1:0]            long_wbck_ready,
    input  logic [NLONG*XLEN-1:0]       long_wbck_pc,
    input  logic [NLONG-1:0]            long_wbck_en,
    input  logic [NLONG*RGIDX_SIZE-1:0] long_wbck_rd,
    input  logic [NLONG*XLEN-1:0]       long_wbck_data,
    input  logic [NLONG-1:0]            long_wbck_mmio,
    input  logic                        oitf_waw_dep,
    output logic                        longi_wbck,
    output logic [idw(NLONG)-1:0]       longi_wbck_id,
    output logic                        wbck_o_valid,
    output logic [XLEN-1:0]             wbck_o_pc,
    output logic                        wbck_o_en,
    output logic [RGIDX_SIZE-1:0]       wbck_o_rd,
    output logic [XLEN-1:0]             wbck_o_data,
    output logic                        wbck_o_lsu
);

    localparam int IW = idw(NLONG);

    if (NLONG < 1 || NLONG > 8 || AGE_LIM < 1 || AGE_LIM > 255) begin : g_bad_cfg
        $error("lieat_exu_wbarb: NLONG or AGE_LIM out of range");
    end

    logic             com_pend_q, com_pend_d;
    logic             any_long, com_gnt, long_any_gnt, aged_any;
    logic [NLONG-1:0] aged, long_gnt;
    logic [IW-1:0]    gid, low_id, aged_id;

`ifdef LIEAT_WBARB_AGE_EN
    for (genvar i = 0; i < NLONG; i++) begin : g_age
        lieat_wbarb_age #(.AGE_LIM(AGE_LIM)) u_age (
            .clk     (clk),
            .rst     (rst),
            .valid_i (long_wbck_valid[i]),
            .grant_i (long_gnt[i]),
            .aged_o  (aged[i])
        );
    end
`else
    assign aged = '0;
`endif

    // Downward scans so the lowest valid (or aged) index wins.
    always_comb begin
        any_long = |long_wbck_valid;
        low_id   = '0;
        aged_id  = '0;
        aged_any = 1'b0;
        for (int i = NLONG - 1; i >= 0; i--) begin
            if (long_wbck_valid[i]) low_id = IW'(i);
            if (long_wbck_valid[i] && aged[i]) begin
                aged_id  = IW'(i);
                aged_any = 1'b1;
            end
        end
        com_gnt      = !rst && (com_pend_q || (com_wbck_valid && !oitf_waw_dep && !any_long));
        long_any_gnt = !rst && !com_pend_q && any_long;
        gid          = long_any_gnt ? (aged_any ? aged_id : low_id) : '0;
        long_gnt     = '0;
        for (int i = 0; i < NLONG; i++) long_gnt[i] = long_any_gnt && (gid == IW'(i));
    end

    always_comb begin
        com_wbck_ready  = com_gnt;
        long_wbck_ready = long_gnt;
        longi_wbck      = long_any_gnt;
        longi_wbck_id   = gid;
        wbck_o_valid    = com_gnt || long_any_gnt;
        wbck_o_pc       = com_gnt ? com_wbck_pc : '0;
        wbck_o_en       = com_gnt && com_wbck_en;
        wbck_o_rd       = com_gnt ? com_wbck_rd : '0;
        wbck_o_data     = com_gnt ? com_wbck_data : '0;
        wbck_o_lsu      = 1'b0;
        for (int i = 0; i < NLONG; i++) begin
            if (long_gnt[i]) begin
                wbck_o_pc   = long_wbck_pc[i*XLEN +: XLEN];
                wbck_o_en   = long_wbck_en[i];
                wbck_o_rd   = long_wbck_rd[i*RGIDX_SIZE +: RGIDX_SIZE];
                wbck_o_data = long_wbck_data[i*XLEN +: XLEN];
                wbck_o_lsu  = long_wbck_mmio[i] && long_wbck_en[i];
            end
        end
    end

    // A hazard-free commit that loses to a long channel is owed the next slot.
    assign com_pend_d = !com_pend_q && com_wbck_valid && !oitf_waw_dep && any_long;

    always_ff @(posedge clk) begin
        if (rst) com_pend_q <= 1'b0;
        else     com_pend_q <= com_pend_d;
    end

endmodule

// File: tb/tb_lieat_exu_wbarb.sv
// tb_lieat_exu_wbarb: directed scenarios plus randomized traffic checked against a rule-level model.
module tb_lieat_exu_wbarb;

    localparam int NLONG = 2;
    localparam int XLEN  = 32;
    localparam int RG    = 5;
    localparam int LIM   = 3;
`ifdef LIEAT_WBARB_AGE_EN
    localparam bit AGE_EN = 1'b1;
`else
    localparam bit AGE_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  com_wbck_valid, com_wbck_ready, com_wbck_en, oitf_waw_dep;
    logic [XLEN-1:0]       com_wbck_pc, com_wbck_data;
    logic [RG-1:0]         com_wbck_rd;
    logic [NLONG-1:0]      long_wbck_valid, long_wbck_ready, long_wbck_en, long_wbck_mmio;
    logic [NLONG*XLEN-1:0] long_wbck_pc, long_wbck_data;
    logic [NLONG*RG-1:0]   long_wbck_rd;
    logic                  longi_wbck, wbck_o_valid, wbck_o_en, wbck_o_lsu;
    logic [0:0]            longi_wbck_id;
    logic [XLEN-1:0]       wbck_o_pc, wbck_o_data;
    logic [RG-1:0]         wbck_o_rd;

    always #5 clk = ~clk;

    lieat_exu_wbarb #(.NLONG(NLONG), .XLEN(XLEN), .RGIDX_SIZE(RG), .AGE_LIM(LIM)) dut (
        .clk(clk), .rst(rst),
        .com_wbck_valid(com_wbck_valid), .com_wbck_ready(com_wbck_ready), .com_wbck_pc(com_wbck_pc),
        .com_wbck_en(com_wbck_en), .com_wbck_rd(com_wbck_rd), .com_wbck_data(com_wbck_data),
        .long_wbck_valid(long_wbck_valid), .long_wbck_ready(long_wbck_ready), .long_wbck_pc(long_wbck_pc),
        .long_wbck_en(long_wbck_en), .long_wbck_rd(long_wbck_rd), .long_wbck_data(long_wbck_data),
        .long_wbck_mmio(long_wbck_mmio), .oitf_waw_dep(oitf_waw_dep),
        .longi_wbck(longi_wbck), .longi_wbck_id(longi_wbck_id),
        .wbck_o_valid(wbck_o_valid), .wbck_o_pc(wbck_o_pc), .wbck_o_en(wbck_o_en),
        .wbck_o_rd(wbck_o_rd), .wbck_o_data(wbck_o_data), .wbck_o_lsu(wbck_o_lsu)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: who is owed a slot, and how long each channel has waited.
    bit m_pend;
    int m_age [NLONG];
    int m_win;
    logic             exp_com_rdy, exp_longi, exp_valid, exp_en, exp_lsu;
    logic [NLONG-1:0] exp_long_rdy;
    logic [0:0]       exp_id;
    logic [XLEN-1:0]  exp_pc, exp_data;
    logic [RG-1:0]    exp_rd;

    task automatic model_eval();
        int aged_ch, low;
        aged_ch = -1;
        low = -1;
        for (int i = NLONG - 1; i >= 0; i--) begin
            if (long_wbck_valid[i]) low = i;
            if (AGE_EN && long_wbck_valid[i] && m_age[i] == LIM) aged_ch = i;
        end
        m_win = -1;
        if (rst) m_win = -1;
        else if (m_pend) m_win = NLONG;
        else if (aged_ch >= 0) m_win = aged_ch;
        else if (low >= 0) m_win = low;
        else if (com_wbck_valid && !oitf_waw_dep) m_win = NLONG;
        exp_com_rdy  = (m_win == NLONG);
        exp_long_rdy = '0;
        exp_longi    = 1'b0;
        exp_id       = '0;
        exp_valid    = (m_win >= 0);
        exp_pc = '0; exp_en = 1'b0; exp_rd = '0; exp_data = '0; exp_lsu = 1'b0;
        if (m_win == NLONG) begin
            exp_pc = com_wbck_pc; exp_en = com_wbck_en; exp_rd = com_wbck_rd; exp_data = com_wbck_data;
        end else if (m_win >= 0) begin
            exp_long_rdy[m_win] = 1'b1;
            exp_longi = 1'b1;
            exp_id    = 1'(m_win);
            exp_pc    = long_wbck_pc[m_win*XLEN +: XLEN];
            exp_en    = long_wbck_en[m_win];
            exp_rd    = long_wbck_rd[m_win*RG +: RG];
            exp_data  = long_wbck_data[m_win*XLEN +: XLEN];
            exp_lsu   = long_wbck_mmio[m_win] && long_wbck_en[m_win];
        end
    endtask

    task automatic tick();
        bit any;
        model_eval();
        any = |long_wbck_valid;
        @(posedge clk);
        if (rst) begin
            m_pend = 1'b0;
            for (int i = 0; i < NLONG; i++) m_age[i] = 0;
        end else begin
            for (int i = 0; i < NLONG; i++)
                m_age[i] = (!long_wbck_valid[i] || m_win == i) ? 0 : (m_age[i] < LIM ? m_age[i] + 1 : LIM);
            m_pend = !m_pend && com_wbck_valid && !oitf_waw_dep && any;
        end
        #1;
    endtask

    task automatic idle();
        com_wbck_valid = 0; com_wbck_pc = '0; com_wbck_en = 0; com_wbck_rd = '0; com_wbck_data = '0;
        long_wbck_valid = '0; long_wbck_pc = '0; long_wbck_en = '0; long_wbck_rd = '0;
        long_wbck_data = '0; long_wbck_mmio = '0; oitf_waw_dep = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; com_wbck_valid = 1; com_wbck_en = 1; com_wbck_data = 32'hDEAD; long_wbck_valid = 2'b11;
        long_wbck_data = {32'h22, 32'h11}; long_wbck_en = 2'b11; long_wbck_mmio = 2'b11;
        #1;
        checks++;
        if ({com_wbck_ready, long_wbck_ready, longi_wbck, longi_wbck_id, wbck_o_valid, wbck_o_en, wbck_o_lsu} !== '0) begin
            errors++; $display("FAIL reset_ctl got=%b exp=0", {com_wbck_ready, long_wbck_ready, longi_wbck, longi_wbck_id, wbck_o_valid, wbck_o_en, wbck_o_lsu});
        end
        checks++;
        if ({wbck_o_pc, wbck_o_rd, wbck_o_data} !== '0) begin
            errors++; $display("FAIL reset_data got pc=%h rd=%h data=%h exp=0", wbck_o_pc, wbck_o_rd, wbck_o_data);
        end
        tick(); tick();
        rst = 0; idle(); tick();
    endtask

    task automatic test_commit_only();
        idle();
        com_wbck_valid = 1; com_wbck_en = 1; com_wbck_rd = 5'd3; com_wbck_data = 32'h55; com_wbck_pc = 32'h100;
        #1;
        checks++;
        if ({com_wbck_ready, wbck_o_valid, longi_wbck, wbck_o_rd, wbck_o_data, wbck_o_pc} !== {1'b1, 1'b1, 1'b0, 5'd3, 32'h55, 32'h100}) begin
            errors++; $display("FAIL commit_only got rdy=%b v=%b li=%b rd=%0d data=%h pc=%h exp 1 1 0 3 55 100",
                com_wbck_ready, wbck_o_valid, longi_wbck, wbck_o_rd, wbck_o_data, wbck_o_pc);
        end
        tick(); idle();
    endtask

    task automatic test_commit_lost();
        idle();
        com_wbck_valid = 1; com_wbck_en = 1; com_wbck_rd = 5'd7; com_wbck_data = 32'hAA; com_wbck_pc = 32'h200;
        long_wbck_valid = 2'b10; long_wbck_data = {32'h1111, 32'h0}; long_wbck_rd = {5'd9, 5'd0}; long_wbck_en = 2'b10;
        #1;
        checks++;
        if ({com_wbck_ready, long_wbck_ready, longi_wbck, longi_wbck_id, wbck_o_data} !== {1'b0, 2'b10, 1'b1, 1'b1, 32'h1111}) begin
            errors++; $display("FAIL lost_ch1 got crdy=%b lrdy=%b li=%b id=%0d data=%h exp 0 10 1 1 1111",
                com_wbck_ready, long_wbck_ready, longi_wbck, longi_wbck_id, wbck_o_data);
        end
        tick();
        oitf_waw_dep = 1;
        #1;
        checks++;
        if ({com_wbck_ready, long_wbck_ready, longi_wbck, wbck_o_valid, wbck_o_rd, wbck_o_data} !== {1'b1, 2'b00, 1'b0, 1'b1, 5'd7, 32'hAA}) begin
            errors++; $display("FAIL pend_grant got crdy=%b lrdy=%b li=%b v=%b rd=%0d data=%h exp 1 00 0 1 7 aa",
                com_wbck_ready, long_wbck_ready, longi_wbck, wbck_o_valid, wbck_o_rd, wbck_o_data);
        end
        tick();
        long_wbck_valid = '0;
        #1;
        checks++;
        if ({com_wbck_ready, wbck_o_valid} !== 2'b00) begin
            errors++; $display("FAIL pend_cleared got crdy=%b v=%b exp 0 0", com_wbck_ready, wbck_o_valid);
        end
        tick(); idle();
    endtask

    task automatic test_dep_block();
        idle();
        com_wbck_valid = 1; oitf_waw_dep = 1; com_wbck_data = 32'h77;
        #1;
        checks++;
        if ({com_wbck_ready, wbck_o_valid, wbck_o_data} !== {2'b00, 32'h0}) begin
            errors++; $display("FAIL dep_block got crdy=%b v=%b data=%h exp 0 0 0", com_wbck_ready, wbck_o_valid, wbck_o_data);
        end
        tick();
        long_wbck_valid = 2'b01;
        #1;
        checks++;
        if ({com_wbck_ready, long_wbck_ready} !== 3'b001) begin
            errors++; $display("FAIL dep_no_pend got crdy=%b lrdy=%b exp 0 01", com_wbck_ready, long_wbck_ready);
        end
        tick();
        long_wbck_valid = '0;
        #1;
        checks++;
        if (com_wbck_ready !== 1'b0) begin
            errors++; $display("FAIL dep_no_pend2 got crdy=%b exp 0", com_wbck_ready);
        end
        tick(); idle(); tick();
    endtask

    task automatic test_age();
        logic [0:0] want;
        idle(); tick();
        long_wbck_valid = 2'b11;
        for (int c = 0; c < 8; c++) begin
            want = (AGE_EN && (c % 4 == 3)) ? 1'b1 : 1'b0;
            #1;
            checks++;
            if ({longi_wbck, longi_wbck_id, long_wbck_ready} !== {1'b1, want, want ? 2'b10 : 2'b01}) begin
                errors++; $display("FAIL age_cycle%0d got li=%b id=%0d lrdy=%b exp id=%0d", c, longi_wbck, longi_wbck_id, long_wbck_ready, want);
            end
            tick();
        end
        idle(); tick();
    endtask

    task automatic test_lsu();
        idle();
        long_wbck_valid = 2'b01; long_wbck_mmio = 2'b01; long_wbck_en = 2'b01;
        #1;
        checks++;
        if ({wbck_o_lsu, longi_wbck, longi_wbck_id} !== 3'b110) begin
            errors++; $display("FAIL lsu_en1 got lsu=%b li=%b id=%0d exp 1 1 0", wbck_o_lsu, longi_wbck, longi_wbck_id);
        end
        tick();
        long_wbck_en = 2'b00;
        #1;
        checks++;
        if ({wbck_o_lsu, wbck_o_valid} !== 2'b01) begin
            errors++; $display("FAIL lsu_en0 got lsu=%b v=%b exp 0 1", wbck_o_lsu, wbck_o_valid);
        end
        tick();
        long_wbck_valid = 2'b11; long_wbck_mmio = 2'b10; long_wbck_en = 2'b11;
        #1;
        checks++;
        if ({wbck_o_lsu, long_wbck_ready} !== 3'b001) begin
            errors++; $display("FAIL lsu_other_ch got lsu=%b lrdy=%b exp 0 01", wbck_o_lsu, long_wbck_ready);
        end
        tick(); idle(); tick();
    endtask

    task automatic test_reset_mid_pend();
        idle();
        com_wbck_valid = 1; com_wbck_data = 32'h99; long_wbck_valid = 2'b01;
        tick();
        rst = 1;
        #1;
        checks++;
        if ({com_wbck_ready, long_wbck_ready, longi_wbck, wbck_o_valid, wbck_o_data} !== '0) begin
            errors++; $display("FAIL rst_pend_out got crdy=%b lrdy=%b li=%b v=%b data=%h exp 0",
                com_wbck_ready, long_wbck_ready, longi_wbck, wbck_o_valid, wbck_o_data);
        end
        tick();
        rst = 0; long_wbck_valid = '0; oitf_waw_dep = 1;
        #1;
        checks++;
        if ({com_wbck_ready, wbck_o_valid} !== 2'b00) begin
            errors++; $display("FAIL rst_pend_dropped got crdy=%b v=%b exp 0 0", com_wbck_ready, wbck_o_valid);
        end
        tick();
        oitf_waw_dep = 0;
        #1;
        checks++;
        if ({com_wbck_ready, wbck_o_data} !== {1'b1, 32'h99}) begin
            errors++; $display("FAIL rst_pend_after got crdy=%b data=%h exp 1 99", com_wbck_ready, wbck_o_data);
        end
        tick(); idle(); tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (!m_pend) begin
                com_wbck_valid = ($urandom_range(0, 2) != 0);
                com_wbck_pc = $urandom; com_wbck_en = 1'($urandom); com_wbck_rd = RG'($urandom); com_wbck_data = $urandom;
            end
            oitf_waw_dep = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NLONG; i++) begin
                long_wbck_valid[i] = ($urandom_range(0, 3) != 0);
                long_wbck_en[i] = 1'($urandom);
                long_wbck_mmio[i] = 1'($urandom);
                long_wbck_pc[i*XLEN +: XLEN] = $urandom;
                long_wbck_data[i*XLEN +: XLEN] = $urandom;
                long_wbck_rd[i*RG +: RG] = RG'($urandom);
            end
            #1;
            model_eval();
            checks++;
            if ({com_wbck_ready, long_wbck_ready, longi_wbck, longi_wbck_id} !== {exp_com_rdy, exp_long_rdy, exp_longi, exp_id}) begin
                errors++; $display("FAIL rand_grant n=%0d got %b exp %b", n,
                    {com_wbck_ready, long_wbck_ready, longi_wbck, longi_wbck_id}, {exp_com_rdy, exp_long_rdy, exp_longi, exp_id});
            end
            checks++;
            if ({wbck_o_valid, wbck_o_en, wbck_o_lsu, wbck_o_rd} !== {exp_valid, exp_en, exp_lsu, exp_rd}) begin
                errors++; $display("FAIL rand_ctl n=%0d got %b exp %b", n,
                    {wbck_o_valid, wbck_o_en, wbck_o_lsu, wbck_o_rd}, {exp_valid, exp_en, exp_lsu, exp_rd});
            end
            checks++;
            if ({wbck_o_pc, wbck_o_data} !== {exp_pc, exp_data}) begin
                errors++; $display("FAIL rand_data n=%0d got pc=%h data=%h exp pc=%h data=%h", n, wbck_o_pc, wbck_o_data, exp_pc, exp_data);
            end
            tick();
        end
        rst = 0; idle(); tick();
    endtask

    initial begin
        m_pend = 1'b0;
        for (int i = 0; i < NLONG; i++) m_age[i] = 0;
        rst = 1;
        idle();
        test_reset();
        test_commit_only();
        test_commit_lost();
        test_dep_block();
        test_age();
        test_lsu();
        test_reset_mid_pend();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lieat_exu_wbarb.md
LIEAT_EXU_WBARB -- requirements
Module: lieat_exu_wbarb

Interface
REQ-001 SHALL have parameter NLONG, default 2: number of long-latency writeback channels (LSU, MULDIV, ...); legal range 1..8.
REQ-002 SHALL have parameter XLEN, default 32: data and PC width.
REQ-003 SHALL have parameter RGIDX_SIZE, default 5: register index width.
REQ-004 SHALL have parameter AGE_LIM, default 7: starvation threshold in cycles; legal range 1..255.
REQ-005 SHALL have these ports (IW = max(1, clog2(NLONG))):
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- com_wbck_valid  in  1  commit-path result valid.
- com_wbck_ready  out  1  commit result accepted this cycle.
- com_wbck_pc  in  XLEN  commit PC.
- com_wbck_en  in  1  commit register-write enable.
- com_wbck_rd  in  RGIDX_SIZE  commit destination.
- com_wbck_data  in  XLEN  commit data.
- long_wbck_valid  in  NLONG  per-channel valid; bit i is channel i.
- long_wbck_ready  out  NLONG  per-channel accept.
- long_wbck_pc  in  NLONG*XLEN  flattened PCs; channel i at slice i.
- long_wbck_en  in  NLONG  per-channel write enable.
- long_wbck_rd  in  NLONG*RGIDX_SIZE  flattened destinations.
- long_wbck_data  in  NLONG*XLEN  flattened data.
- long_wbck_mmio  in  NLONG  channel result came from MMIO.
- oitf_waw_dep  in  1  commit result has a WAW hazard against an outstanding long instruction.
- longi_wbck  out  1  a long channel is granted this cycle (OITF retire strobe).
- longi_wbck_id  out  IW  index of the granted long channel; 0 when longi_wbck=0.
- wbck_o_valid  out  1  regfile write-port valid.
- wbck_o_pc  out  XLEN  winner PC.
- wbck_o_en  out  1  winner write enable.
- wbck_o_rd  out  RGIDX_SIZE  winner destination.
- wbck_o_data  out  XLEN  winner data.
- wbck_o_lsu  out  1  granted long channel with mmio=1 and en=1.

Function
REQ-006 SHALL grant at most one source per cycle, highest priority first:
- com_pend.
- Aged long channel: lowest index with age == AGE_LIM.
- Lowest-index valid long channel.
- Commit, only when oitf_waw_dep = 0.
REQ-007 SHALL raise only the winner's ready, combinationally in the same cycle (zero latency); wbck_o_valid = a winner exists; wbck_o_* carry the winner's fields; wbck_o_* = 0 when there is no winner.
REQ-008 SHALL set com_pend on the clock edge when com_wbck_valid=1, oitf_waw_dep=0, com_pend=0 and any long channel is valid (commit lost to a long channel).
REQ-009 While com_pend=1, SHALL grant commit unconditionally (ignoring oitf_waw_dep and long valids), then clear com_pend on that edge; upstream holds the commit payload stable while it waits.
REQ-010 SHALL keep a per-channel age counter of width clog2(AGE_LIM+1):
- Increments each cycle the channel is valid and not granted.
- Saturates at AGE_LIM.
- Returns to 0 when the channel is granted or its valid is 0.
REQ-011 SHALL drive longi_wbck=1 and longi_wbck_id=i exactly on the cycles channel i is granted.
REQ-012 With NLONG=1, SHALL drive longi_wbck_id=0 and keep every other rule unchanged.

Reset
REQ-013 While rst=1: all ready outputs, wbck_o_valid, wbck_o_*, longi_wbck and longi_wbck_id SHALL be 0; the next edge SHALL clear com_pend and all age counters, including mid-pend (the pending commit is dropped).

Configuration
REQ-014 SHALL use macro LIEAT_WBARB_AGE_EN:
- Defined: age counters and the aged-priority level are present.
- Undefined: no counters are built, arbitration is pure fixed priority (com_pend > lowest index > commit), and AGE_LIM is ignored.

Structure
REQ-015 Shared package lieat_wbarb_pkg SHALL hold the XLEN/RGIDX_SIZE defaults, the AGE_LIM default and a clog2 helper; sub-module lieat_wbarb_age (saturating per-channel age counter) SHALL be instantiated NLONG times under the macro.

Verification
REQ-016 Bench SHALL cover these directed scenarios:
- Commit only, valid=1, dep=0, rd=3, data=0x55 -> com_wbck_ready=1, wbck_o_valid=1, rd=3, data=0x55, longi_wbck=0 in the same cycle.
- Commit + ch1 valid, dep=0 -> ch1 granted (longi_wbck_id=1), com_pend=1; next cycle commit granted with ch1 still valid; com_pend=0 after.
- Commit valid with dep=1, no long channels -> no grant, wbck_o_valid=0, com_pend stays 0.
- AGE_EN, AGE_LIM=3, ch0 and ch1 valid continuously -> ch0 granted cycles 0-2, ch1 granted cycle 3, ch1 age returns to 0.
- ch0 mmio=1, en=1 granted -> wbck_o_lsu=1; the same with en=0 -> wbck_o_lsu=0.
- rst=1 asserted while com_pend=1 -> all outputs 0; after release, commit waits for dep=0 like any other commit.
